// File: rtl/produttore.sv
// produttore: producer stage for the dav_/rfd byte link.
// Accepts nonzero bytes through a valid/ready port into a small FIFO and
// hands them to the consumer one at a time. Zero bytes are dropped and
// counted, since the consumer cannot count down from zero.
module produttore #(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     src_valid,
    input  logic [7:0]               src_data,
    output logic                     src_ready,
    input  logic                     rfd,
    output logic                     dav_,
    output logic [7:0]               numero,
    output logic [$clog2(DEPTH):0]   level,
    output logic [7:0]               drop_cnt
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    // Handshake states: idle, value offered, waiting for rfd to return high
    localparam logic [1:0] S0 = 2'd0;
    localparam logic [1:0] S1 = 2'd1;
    localparam logic [1:0] S2 = 2'd2;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [1:0]    state;
    logic          push;
    logic          pop;
    logic          drop;
    logic          offer;

    // Ready looks only at the current level, so a full FIFO refuses a push
    // even on an edge where it also pops.
    assign src_ready = (level != LW'(DEPTH));
    assign push      = src_valid & src_ready & (src_data != 8'd0);
    assign drop      = src_valid & src_ready & (src_data == 8'd0);
    assign offer     = (state == S0) & (level != '0) & rfd;
    assign pop       = (state == S1) & ~rfd;

    // FIFO storage; contents need no reset because the pointers define validity
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= src_data;
        end
    end

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap for free
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    // Saturating count of discarded zero values
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            drop_cnt <= 8'd0;
        end else if (drop && (drop_cnt != 8'hff)) begin
            drop_cnt <= drop_cnt + 8'd1;
        end
    end

    // Handshake FSM; numero is loaded only when a new value is offered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= S0;
            dav_   <= 1'b1;
            numero <= 8'd0;
        end else begin
            case (state)
                S0: begin
                    if (offer) begin
                        numero <= mem[rd_ptr];
                        dav_   <= 1'b0;
                        state  <= S1;
                    end
                end
                S1: begin
                    if (!rfd) begin
                        dav_  <= 1'b1;
                        state <= S2;
                    end
                end
                S2: begin
                    // Wait for rfd high so the consumer never sees a stale offer
                    if (rfd) begin
                        state <= S0;
                    end
                end
                default: begin
                    dav_  <= 1'b1;
                    state <= S0;
                end
            endcase
        end
    end

endmodule

// File: doc/produttore.md
# produttore

Upstream producer stage for the byte consumer on the `dav_`/`rfd` link. It accepts 8-bit values from a local source through a valid/ready port, buffers them in a small FIFO and delivers them one at a time over the `dav_`/`rfd` handshake. Zero values are discarded at the input, because the consumer cannot count down from zero, and each discard is counted.

## Interface
- `DEPTH`, default 4: FIFO entries; power of two, 2..16.
- `clock`  in  1  sole clock, rising-edge active.
- `reset`  in  1  asynchronous, active-high; clears all state immediately.
- `src_valid`  in  1  source presents `src_data` this cycle.
- `src_data`  in  8  value offered by the source.
- `src_ready`  out  1  FIFO can accept; equals not-full.
- `rfd`  in  1  consumer ready-for-data; high from consumer reset.
- `dav_`  out  1  data-available, active-low.
- `numero`  out  8  value offered to the consumer; registered.
- `level`  out  log2(DEPTH)+1  current FIFO occupancy.
- `drop_cnt`  out  8  zero values discarded since reset; saturates at 255.

## Operation
- Reset values: `dav_`=1, `numero`=0, `level`=0, `drop_cnt`=0, `src_ready`=1, state S0, FIFO pointers 0.
- Push: occurs on a rising edge when `src_valid`=1, `src_ready`=1 and `src_data`≠0; writes the tail entry and increments `level`.
- Zero discard: `src_valid`=1, `src_ready`=1 and `src_data`=0 does not push; `drop_cnt` increments unless already 255.
- `src_ready` is computed from `level` before any same-cycle pop. When the FIFO is full, no push occurs even if a pop happens on that edge.
- State S0, idle:
  - `dav_`=1.
  - If `level`>0 and `rfd`=1: `numero`<=head entry, `dav_`<=0, go to S1.
  - Otherwise stay in S0.
- State S1, offered:
  - `dav_`=0 and `numero` held.
  - When `rfd`=0 is sampled: `dav_`<=1, pop the head (read pointer +1, `level`-1), go to S2.
  - Otherwise stay in S1.
- State S2, release:
  - `dav_`=1.
  - When `rfd`=1 is sampled: go to S0.
  - Otherwise stay in S2.
- `numero` changes only on the S0→S1 transition and holds its value through S1, S2 and the following S0.
- Pointers wrap modulo DEPTH. `level` never exceeds DEPTH and never underflows.
- Push and pop on the same edge: `level` is unchanged and both pointers advance.
- Reset mid-handshake, in any state: `dav_` returns to 1 immediately and buffered data is lost.

## Timing
- All outputs are registered except `src_ready`, which is decoded from `level`.
- Latency with an empty FIFO and `rfd`=1: push at edge k, then `dav_`=0 with valid `numero` after edge k+1.
- `dav_` stays 0 until the first edge at which `rfd`=0 is sampled, then rises after that edge.
- A new offer requires `rfd` to be sampled 1 in S2 and then again in S0, so the minimum time from one `dav_` fall to the next is 3 edges plus the consumer's response time.
- The consumer must never see `dav_`=0 while `rfd`=1 after it has dropped `rfd`. S2 guarantees this.

## Test plan
- Reset release, then push 5 with `rfd`=1 → `dav_`=0 and `numero`=5 one edge after the push. A model consumer drops `rfd` 2 edges later → `dav_`=1 on the next edge and `level`=0.
- Push 3, 7, 9, 2 back-to-back while holding `rfd`=0 → `level`=4, `src_ready`=0, and a fifth push of 11 is ignored. Releasing `rfd` delivers 3, 7, 9, 2 in order.
- Push 0, 0, 4 → `drop_cnt`=2 and only 4 is offered. 300 zero pushes → `drop_cnt` holds at 255.
- Full FIFO with a pop in S1 on the same edge as `src_valid`=1 → no push that edge; `src_ready`=1 on the next cycle and the push succeeds then.
- Assert `reset` while in S1 with `dav_`=0 and `level`=3 → `dav_`=1 asynchronously, `level`=0 and `numero`=0; after release the block idles in S0.
- Run 20 random nonzero values against the counting consumer model → every value is consumed exactly once, in order, with `numero` stable while `dav_`=0 and no `dav_` fall while the consumer is in its release state.
